// File: rtl/alu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_stage_pkg
// Description : Shared types and opcode constants for the ALU result stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   localparam logic [3:0]  ALUOP_DIV         = 4'h3;
   localparam logic [3:0]  ALUOP_NOP         = 4'hE;
   localparam logic [15:0] HILO_MASK_DEFAULT = 16'h0E7B;

   // Where an accepted opcode sends the FSM next.
   function automatic state_t accept_target(input logic [3:0] op);
      if (op == ALUOP_NOP)
         return ST_IDLE;
      else if (op == ALUOP_DIV)
         return ST_EXEC;
      else
         return ST_WB;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_stage_timeout.sv
`default_nettype none
// ============================================================================
// Module      : alu_stage_timeout
// Description : Clearable saturating up-counter flagging LIMIT-1 reached.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stage_timeout #(
   parameter int LIMIT = 64,
   parameter int WIDTH = $clog2(LIMIT) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);
   localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_count <= '0;
      else if (clr)
         r_count <= '0;
      else if (en && (r_count != c_max))
         r_count <= r_count + 1'b1;
   end

   assign expired = (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Captures ALU results, keeps HI/LO, and issues one writeback beat.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
   import alu_stage_pkg::*;
#(
   parameter logic [15:0] HILO_MASK   = HILO_MASK_DEFAULT,
   parameter int          DIV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic [3:0]  issue_aluop,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] res_high,
   input  logic [31:0] res_low,
   input  logic        zero,
   input  logic        inst_done,
   output logic        stall,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        zero_flag,
   output logic        timeout_err
);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_aluop;
   logic [4:0]  r_rd;
   logic [31:0] r_wb_data;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_zf;
   logic        r_terr;

   logic        w_rd_zero;
   logic        w_wb_exit;
   logic        w_stall;
   logic        w_accept;
   logic        w_div_start;
   logic        w_capture;
   logic        w_timeout;
   logic        w_expired;
   logic [3:0]  w_cap_op;

   assign w_rd_zero   = (r_rd == 5'd0);
   assign w_wb_exit   = (r_state == ST_WB) && (wb_ready || w_rd_zero);
   assign w_stall     = (r_state == ST_EXEC) || ((r_state == ST_WB) && !w_wb_exit);
   assign w_accept    = issue_valid && ((r_state == ST_IDLE) || w_wb_exit);
   assign w_div_start = w_accept && (issue_aluop == ALUOP_DIV);
   assign w_timeout   = (r_state == ST_EXEC) && !inst_done && w_expired;

   // A divide captures from its own latched opcode; everything else from the issue port.
   assign w_cap_op  = (r_state == ST_EXEC) ? r_aluop : issue_aluop;
   assign w_capture = ((r_state == ST_EXEC) && inst_done) ||
                      (w_accept && (issue_aluop != ALUOP_DIV) && (issue_aluop != ALUOP_NOP));

   alu_stage_timeout #(
      .LIMIT (DIV_TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_div_start),
      .en      (r_state == ST_EXEC),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept)
               w_next = accept_target(issue_aluop);
         end
         ST_EXEC: begin
            if (inst_done)
               w_next = ST_WB;
            else if (w_expired)
               w_next = ST_IDLE;
         end
         ST_WB: begin
            if (w_accept)
               w_next = accept_target(issue_aluop);
            else if (w_wb_exit)
               w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_aluop   <= 4'd0;
         r_rd      <= 5'd0;
         r_wb_data <= 32'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_zf      <= 1'b0;
         r_terr    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_aluop <= issue_aluop;
            r_rd    <= issue_rd;
         end
         if (w_capture) begin
            r_wb_data <= res_low;
            r_zf      <= zero;
            if (HILO_MASK[w_cap_op]) begin
               r_hi <= res_high;
               r_lo <= res_low;
            end
         end
         if (w_timeout)
            r_terr <= 1'b1;
      end
   end

   assign stall       = w_stall;
   assign wb_valid    = (r_state == ST_WB) && !w_rd_zero;
   assign wb_rd       = r_rd;
   assign wb_data     = r_wb_data;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign zero_flag   = r_zf;
   assign timeout_err = r_terr;

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Result-capture and writeback stage that sits directly downstream of the ALU. It accepts one issued ALU operation at a time and waits for multi-cycle completion (DIV). It then latches `res_high`/`res_low`/`zero`, maintains architectural HI/LO registers, and presents a single writeback beat to the register file over a valid/ready handshake. While an operation is outstanding it stalls the issue side, so the ALU operands stay stable.

## Interface
Parameters:
- `HILO_MASK`, default 16'h0E7B: bit k set means aluop k updates HI/LO on completion.
- `DIV_TIMEOUT`, default 64: maximum number of EXEC cycles before the operation is abandoned.

Ports:
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `issue_valid` input 1: an operation is presented.
- `issue_aluop` input 4: opcode; the same value drives the ALU `aluop`.
- `issue_rd` input 5: destination register.
- `res_high` input 32: ALU high result.
- `res_low` input 32: ALU low result.
- `zero` input 1: ALU zero flag.
- `inst_done` input 1: ALU InstDone.
- `stall` output 1: issue not accepted this cycle; upstream holds operands and aluop.
- `wb_valid` output 1: writeback beat valid.
- `wb_ready` input 1: register file accepts the beat.
- `wb_rd` output 5: writeback destination.
- `wb_data` output 32: captured `res_low`.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.
- `zero_flag` output 1: zero flag of the last completed op.
- `timeout_err` output 1: sticky error, set when a DIV exceeds the timeout.

## Operation
- FSM states: IDLE, EXEC, WB.
- Reset values: state IDLE; `wb_valid`, `wb_rd`, `wb_data`, `hi`, `lo`, `zero_flag` and `timeout_err` are all 0; `stall` is 0.
- Accept condition: `issue_valid && !stall` while in IDLE, or in WB with `wb_ready`. On accept, latch `issue_aluop` and `issue_rd`.
- Accept of aluop 4'hE (NOP): nothing is captured and nothing is written back; the next state is IDLE.
- Accept of aluop 4'h3 (DIV): always enter EXEC and clear the timeout counter. `inst_done` in the accept cycle is ignored, because it can be stale from the previous divide.
- Accept of any other aluop: capture results in the same cycle (`inst_done` is 1 for these ops), then go to WB.
- In EXEC, when `inst_done`=1: capture results and go to WB.
- In EXEC, when the counter reaches DIV_TIMEOUT-1 without `inst_done`: set `timeout_err`, return to IDLE, no writeback.
- Capture writes `wb_data`←`res_low` and `zero_flag`←`zero`. If `HILO_MASK[aluop]` is set, it also writes `hi`←`res_high` and `lo`←`res_low`.
- `wb_valid` is high in WB only if the latched rd≠0. With rd=0 the WB state is left after exactly one cycle regardless of `wb_ready`; HI/LO and `zero_flag` are still updated.
- In WB, `wb_valid`, `wb_rd` and `wb_data` hold stable until `wb_ready`.
- WB exit: on `wb_ready` (or rd=0) go to IDLE, or straight to the next op if a new accept happens in the same cycle.
- `stall` = (state==EXEC) || (state==WB && !(wb_ready || rd==0)).
- `timeout_err` clears only on reset.

## Timing
- Single-cycle op accepted at cycle N: `wb_valid`=1 at N+1. Back-to-back ops give one op per cycle while `wb_ready` stays 1.
- DIV accepted at N: the earliest capture is at N+1 (when `inst_done`=1 in the first EXEC cycle), giving `wb_valid` at N+2.
- `hi`, `lo` and `zero_flag` update on the capture edge and are visible the cycle after capture.
- Reset in any state, including mid-DIV or while `wb_valid` is held: the next cycle is IDLE with all outputs at their reset values; the in-flight op is lost.
- Timeout counter: 7 bits ($clog2 of DIV_TIMEOUT, plus one bit); it saturates and does not wrap.

## Structure
- Package `alu_stage_pkg` holds:
  - the state enum;
  - `ALUOP_DIV`=4'h3 and `ALUOP_NOP`=4'hE;
  - the default `HILO_MASK`.
- Sub-module `alu_stage_timeout`: a loadable saturating counter with `clr`, `en` and an `expired` output. The rest of the block is a single FSM.

## Test plan
- ADD (aluop 0), rd=5, `res_low`=32'h12, `res_high`=0, `wb_ready`=1 -> `wb_valid` the next cycle, `wb_data`=0x12, `wb_rd`=5, `lo`=0x12, `zero_flag`=0.
- DIV (aluop 3) with `inst_done` low for 10 cycles, quotient 7, remainder 2 -> `stall` high for 10 cycles, then `wb_data`=7, `hi`=2, `lo`=7.
- SLTI (aluop 2) result 1 while `hi`/`lo` hold 0xA/0xB -> `wb_data`=1 and `hi`/`lo` unchanged (mask bit 2 is 0).
- `wb_ready` held low for 3 cycles during WB -> `wb_valid` and `wb_data` stable and `stall`=1 throughout; the beat completes on the first `wb_ready`.
- DIV with `inst_done` never asserted -> after 64 EXEC cycles `timeout_err`=1, return to IDLE, no `wb_valid`.
- `rst_n`=0 mid-DIV -> the next cycle has the FSM in IDLE, `stall`=0 and all outputs 0; a subsequent NOP (4'hE) produces no `wb_valid`.
